rib_gpio_n: RTL and testbench
=============================

RIB_GPIO_N -- requirements
Module: rib_gpio_n

Interface
REQ-001 SHALL have parameter GPIO_W, default 24, number of GPIO pins (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth (2..4).
REQ-003 SHALL have port i_clk  input  1  single clock for all logic.
REQ-004 SHALL have port i_rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_ribs_addr  input  32  byte address; only bits [4:2] decoded.
REQ-006 SHALL have port i_ribs_wrcs  input  1  1=write, 0=read.
REQ-007 SHALL have port i_ribs_mask  input  4  write byte enables.
REQ-008 SHALL have port i_ribs_wdata  input  32  write data.
REQ-009 SHALL have port o_ribs_rdata  output  32  read data, valid while o_ribs_rsp=1.
REQ-010 SHALL have port i_ribs_req  input  1  request valid.
REQ-011 SHALL have port o_ribs_gnt  output  1  request accepted this cycle when high with i_ribs_req.
REQ-012 SHALL have port o_ribs_rsp  output  1  response valid.
REQ-013 SHALL have port i_ribs_rdy  input  1  master accepts response.
REQ-014 SHALL have port o_gpio_mode  output  GPIO_W  per-pin direction, 1=output.
REQ-015 SHALL have port o_gpio_out  output  GPIO_W  per-pin output value.
REQ-016 SHALL have port i_gpio_in  input  GPIO_W  asynchronous pad inputs.
REQ-017 SHALL have port o_irq  output  1  OR of enabled pending bits.

Function
REQ-018 SHALL decode offsets: 0x00 MODE rw, 0x04 OUT rw, 0x08 IN ro, 0x0C RISE_EN rw, 0x10 FALL_EN rw, 0x14 PEND w1c, 0x18 OUT_SET wo (reads 0), 0x1C OUT_CLR wo (reads 0).
REQ-019 SHALL drive o_ribs_gnt = ~o_ribs_rsp | i_ribs_rdy; accept = i_ribs_req & o_ribs_gnt.
REQ-020 SHALL assert o_ribs_rsp the cycle after accept, holding rsp and rdata stable until i_ribs_rdy=1; back-to-back accept on rdy cycle keeps rsp high with new data.
REQ-021 SHALL apply writes at the accept edge, honouring i_ribs_mask per byte; writes respond with rdata=0.
REQ-022 SHALL capture read data at the accept edge (IN value = synchroniser output at that edge).
REQ-023 SHALL read bits [31:GPIO_W] as 0 and ignore writes to them.
REQ-024 SHALL pass i_gpio_in through a SYNC_STAGES flop chain, then a prev register; rise = sync & ~prev & RISE_EN, fall = ~sync & prev & FALL_EN.
REQ-025 SHALL set PEND bits on rise|fall; when an edge and a W1C of the same bit coincide, set wins.
REQ-026 SHALL OUT_SET write do OUT |= wdata; OUT_CLR do OUT &= ~wdata; masked per byte.
REQ-027 SHALL drive o_irq = |PEND, registered-free from PEND (combinational OR).
REQ-028 SHALL suppress edge detection for SYNC_STAGES+1 cycles after reset release via an arm counter, so pins high at reset create no pending bits.
REQ-029 SHALL set PEND at the (SYNC_STAGES+1)th rising clock edge after a pin change is first sampled.
REQ-030 SHALL decode unmapped/any addr[31:5] by aliasing on [4:2] with no error response.

Reset
REQ-031 SHALL on i_rstn=0 asynchronously clear MODE, OUT, RISE_EN, FALL_EN, PEND, synchroniser, prev, arm counter, o_ribs_rsp, o_ribs_rdata to 0.
REQ-032 SHALL abandon an in-flight response on reset mid-transaction; o_ribs_gnt reads 1 after reset.

Structure
REQ-033 SHALL place register offset constants and GPIO_W default in the shared defines package.
REQ-034 SHALL use one sub-module gpio_sync (parametrised width and depth flop chain), instantiated once.

Verification
REQ-035 SHALL cover: write MODE=0x00000F mask=0xF, read MODE -> rsp next cycle, rdata=0x00000F, o_gpio_mode=0x00000F.
REQ-036 SHALL cover: OUT=0x0000F0, write OUT_SET 0x3, write OUT_CLR 0x10 -> OUT reads 0x0000E3.
REQ-037 SHALL cover: RISE_EN=0x1, pin0 0->1 -> PEND=0x1 and o_irq=1 after 3 edges (SYNC_STAGES=2); write PEND 0x1 -> PEND=0, o_irq=0.
REQ-038 SHALL cover: pin1 fall coinciding with W1C of bit1, FALL_EN=0x2 -> PEND bit1 remains 1.
REQ-039 SHALL cover: i_ribs_rdy held 0 for 3 cycles after read -> rsp and rdata stable, gnt=0; rdy=1 with new req -> gnt=1, rsp stays high with new data.
REQ-040 SHALL cover: all pins high through reset release, RISE_EN=all -> PEND stays 0; reset asserted mid-response -> rsp=0 immediately.

Source files
------------

// File: rtl/rib_gpio_n_pkg.sv
// rib_gpio_n_pkg: register map and defaults shared by the GPIO block
package rib_gpio_n_pkg;

    localparam int GPIO_W_DEF = 24;

    localparam logic [4:0] OFF_MODE    = 5'h00;
    localparam logic [4:0] OFF_OUT     = 5'h04;
    localparam logic [4:0] OFF_IN      = 5'h08;
    localparam logic [4:0] OFF_RISE_EN = 5'h0C;
    localparam logic [4:0] OFF_FALL_EN = 5'h10;
    localparam logic [4:0] OFF_PEND    = 5'h14;
    localparam logic [4:0] OFF_OUT_SET = 5'h18;
    localparam logic [4:0] OFF_OUT_CLR = 5'h1C;

    typedef enum logic [2:0] {
        REG_MODE    = 3'(OFF_MODE >> 2),
        REG_OUT     = 3'(OFF_OUT >> 2),
        REG_IN      = 3'(OFF_IN >> 2),
        REG_RISE_EN = 3'(OFF_RISE_EN >> 2),
        REG_FALL_EN = 3'(OFF_FALL_EN >> 2),
        REG_PEND    = 3'(OFF_PEND >> 2),
        REG_OUT_SET = 3'(OFF_OUT_SET >> 2),
        REG_OUT_CLR = 3'(OFF_OUT_CLR >> 2)
    } reg_e;

endpackage

// File: rtl/rib_gpio_n_gpio_sync.sv
// gpio_sync: DEPTH-stage flop chain bringing asynchronous pads into i_clk
module gpio_sync #(
    parameter int W     = 1,
    parameter int DEPTH = 2
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [DEPTH-1:0][W-1:0] chain_q;

    // shift pads through the chain; last stage is the synchronised value
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) chain_q <= '0;
        else chain_q <= {chain_q[DEPTH-2:0], i_d};
    end

    assign o_q = chain_q[DEPTH-1];

endmodule

// File: rtl/rib_gpio_n.sv
// rib_gpio_n: RIB-slave GPIO block with direction/output regs and edge interrupts
module rib_gpio_n
    import rib_gpio_n_pkg::*;
#(
    parameter int GPIO_W      = GPIO_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [31:0]       i_ribs_addr,
    input  logic              i_ribs_wrcs,
    input  logic [3:0]        i_ribs_mask,
    input  logic [31:0]       i_ribs_wdata,
    output logic [31:0]       o_ribs_rdata,
    input  logic              i_ribs_req,
    output logic              o_ribs_gnt,
    output logic              o_ribs_rsp,
    input  logic              i_ribs_rdy,
    output logic [GPIO_W-1:0] o_gpio_mode,
    output logic [GPIO_W-1:0] o_gpio_out,
    input  logic [GPIO_W-1:0] i_gpio_in,
    output logic              o_irq
);

    localparam logic [2:0] ARM_N = 3'(SYNC_STAGES + 1);

    logic [GPIO_W-1:0] mode_q, mode_d, out_q, out_d;
    logic [GPIO_W-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [GPIO_W-1:0] pend_q, pend_d, prev_q;
    logic [GPIO_W-1:0] sync_w, edge_w, bm, wd;
    logic [2:0]        arm_q, arm_d;
    logic              rsp_q, rsp_d;
    logic [31:0]       rdata_q, rdata_d, rd_val;
    logic              accept, unused_bits;
    reg_e              sel;

    gpio_sync #(.W(GPIO_W), .DEPTH(SYNC_STAGES)) u_sync (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_d    (i_gpio_in),
        .o_q    (sync_w)
    );

    assign o_ribs_gnt  = ~rsp_q | i_ribs_rdy;
    assign accept      = i_ribs_req & o_ribs_gnt;
    assign sel         = reg_e'(i_ribs_addr[4:2]);
    assign unused_bits = ^{i_ribs_addr, i_ribs_wdata};
    assign edge_w      = (arm_q == ARM_N) ? ((sync_w & ~prev_q & rise_en_q) | (~sync_w & prev_q & fall_en_q)) : '0;

    // expand byte enables to bits and select the register being read
    always_comb begin
        for (int i = 0; i < GPIO_W; i++) bm[i] = i_ribs_mask[2'(i / 8)];
        wd = i_ribs_wdata[GPIO_W-1:0] & bm;
        rd_val = '0;
        case (sel)
            REG_MODE:    rd_val[GPIO_W-1:0] = mode_q;
            REG_OUT:     rd_val[GPIO_W-1:0] = out_q;
            REG_IN:      rd_val[GPIO_W-1:0] = sync_w;
            REG_RISE_EN: rd_val[GPIO_W-1:0] = rise_en_q;
            REG_FALL_EN: rd_val[GPIO_W-1:0] = fall_en_q;
            REG_PEND:    rd_val[GPIO_W-1:0] = pend_q;
            default:     rd_val = '0;
        endcase
    end

    // next state: response handshake, register writes, pending set beats clear
    always_comb begin
        mode_d    = mode_q;
        out_d     = out_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        pend_d    = pend_q | edge_w;
        rsp_d     = rsp_q & ~i_ribs_rdy;
        rdata_d   = rdata_q;
        arm_d     = (arm_q == ARM_N) ? arm_q : arm_q + 3'd1;
        if (accept) begin
            rsp_d   = 1'b1;
            rdata_d = i_ribs_wrcs ? '0 : rd_val;
        end
        if (accept && i_ribs_wrcs) begin
            case (sel)
                REG_MODE:    mode_d    = (mode_q & ~bm) | wd;
                REG_OUT:     out_d     = (out_q & ~bm) | wd;
                REG_RISE_EN: rise_en_d = (rise_en_q & ~bm) | wd;
                REG_FALL_EN: fall_en_d = (fall_en_q & ~bm) | wd;
                REG_PEND:    pend_d    = (pend_q & ~wd) | edge_w;
                REG_OUT_SET: out_d     = out_q | wd;
                REG_OUT_CLR: out_d     = out_q & ~wd;
                default:     ;
            endcase
        end
    end

    // state registers, all cleared asynchronously
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            mode_q    <= '0;
            out_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            pend_q    <= '0;
            prev_q    <= '0;
            arm_q     <= '0;
            rsp_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            mode_q    <= mode_d;
            out_q     <= out_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            pend_q    <= pend_d;
            prev_q    <= sync_w;
            arm_q     <= arm_d;
            rsp_q     <= rsp_d;
            rdata_q   <= rdata_d;
        end
    end

    assign o_ribs_rsp   = rsp_q;
    assign o_ribs_rdata = rdata_q;
    assign o_gpio_mode  = mode_q;
    assign o_gpio_out   = out_q;
    assign o_irq        = |pend_q;

endmodule

// File: tb/tb_rib_gpio_n.sv
// tb_rib_gpio_n: directed and random checks of rib_gpio_n against a behavioural model
module tb_rib_gpio_n;

    localparam int W = 24;
    localparam int S = 2;
    localparam logic [31:0] WM = 32'((64'd1 << W) - 1);

    logic          clk = 1'b0;
    logic          rstn, req, wrcs, rdy, gnt, rsp, irq;
    logic [31:0]   addr, wdata, rdata;
    logic [3:0]    mask;
    logic [W-1:0]  mode, out, gin;
    int            n_chk = 0;
    int            n_fail = 0;
    logic          mon_en = 1'b0;

    rib_gpio_n #(.GPIO_W(W), .SYNC_STAGES(S)) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_ribs_addr  (addr),
        .i_ribs_wrcs  (wrcs),
        .i_ribs_mask  (mask),
        .i_ribs_wdata (wdata),
        .o_ribs_rdata (rdata),
        .i_ribs_req   (req),
        .o_ribs_gnt   (gnt),
        .o_ribs_rsp   (rsp),
        .i_ribs_rdy   (rdy),
        .o_gpio_mode  (mode),
        .o_gpio_out   (out),
        .i_gpio_in    (gin),
        .o_irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // behavioural model: registers as plain words, pads seen through a sample history
    logic [31:0] m_mode, m_out, m_rise, m_fall, m_pend, m_rdata;
    logic [31:0] samp [0:S];
    logic [31:0] m_sync, m_prev, m_ev, m_sel, m_rd;
    logic        m_rsp;
    int          ecnt;

    function automatic logic [31:0] bytewr(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r & WM;
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] idx);
        case (idx)
            3'd0: return m_mode;
            3'd1: return m_out;
            3'd2: return samp[S-1];
            3'd3: return m_rise;
            3'd4: return m_fall;
            3'd5: return m_pend;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_mode = 0; m_out = 0; m_rise = 0; m_fall = 0; m_pend = 0;
            m_rsp = 0; m_rdata = 0; ecnt = 0;
            for (int i = 0; i <= S; i++) samp[i] = 0;
        end else begin
            m_sync = samp[S-1];
            m_prev = samp[S];
            m_ev = (ecnt >= S + 1) ? ((m_sync & ~m_prev & m_rise) | (~m_sync & m_prev & m_fall)) : 32'h0;
            if (req && (!m_rsp || rdy)) begin
                m_rd  = wrcs ? 32'h0 : m_read(addr[4:2]);
                m_sel = bytewr(32'h0, wdata, mask);
                if (wrcs) begin
                    case (addr[4:2])
                        3'd0: m_mode = bytewr(m_mode, wdata, mask);
                        3'd1: m_out  = bytewr(m_out, wdata, mask);
                        3'd3: m_rise = bytewr(m_rise, wdata, mask);
                        3'd4: m_fall = bytewr(m_fall, wdata, mask);
                        3'd5: m_pend = m_pend & ~m_sel;
                        3'd6: m_out  = m_out | m_sel;
                        3'd7: m_out  = m_out & ~m_sel;
                        default: ;
                    endcase
                end
                m_rsp = 1;
                m_rdata = m_rd;
            end else if (rdy) begin
                m_rsp = 0;
            end
            m_pend = m_pend | m_ev;
            for (int i = S; i > 0; i--) samp[i] = samp[i-1];
            samp[0] = 32'(gin);
            if (ecnt < 100) ecnt++;
        end
    end

    // continuous comparison against the model just after each active edge
    always @(posedge clk) begin
        #1;
        if (mon_en && rstn) begin
            check("mon_rsp", 32'(rsp), 32'(m_rsp));
            check("mon_gnt", 32'(gnt), 32'(!m_rsp || rdy));
            check("mon_mode", 32'(mode), m_mode);
            check("mon_out", 32'(out), m_out);
            check("mon_irq", 32'(irq), 32'(m_pend != 0));
            if (m_rsp) check("mon_rdata", rdata, m_rdata);
        end
    end

    // one transfer with rdy=1, called just after a falling edge
    task automatic xfer(input logic wr, input logic [2:0] idx, input logic [3:0] m, input logic [31:0] d, output logic [31:0] r);
        logic [31:0] a;
        a = $urandom;
        a[4:2] = idx;
        req = 1; wrcs = wr; addr = a; mask = m; wdata = d; rdy = 1;
        @(negedge clk);
        req = 0;
        check("xfer_rsp", 32'(rsp), 32'h1);
        if (wr) check("wr_rdata", rdata, 32'h0);
        r = rdata;
    endtask

    initial begin
        logic [31:0] r;
        int p;
        rstn = 1; req = 0; wrcs = 0; addr = 0; mask = 0; wdata = 0; rdy = 1; gin = '0;
        #1 rstn = 0;
        repeat (2) @(negedge clk);
        check("rst_rsp", 32'(rsp), 32'h0);
        check("rst_gnt", 32'(gnt), 32'h1);
        check("rst_rdata", rdata, 32'h0);
        check("rst_mode", 32'(mode), 32'h0);
        check("rst_out", 32'(out), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        rstn = 1;
        mon_en = 1;
        repeat (5) @(negedge clk);

        xfer(1, 3'd0, 4'hF, 32'h0000_000F, r);
        xfer(0, 3'd0, 4'hF, 32'h0, r);
        check("mode_rd", r, 32'h0000_000F);
        check("gpio_mode", 32'(mode), 32'h0000_000F);

        xfer(1, 3'd1, 4'hF, 32'h0000_00F0, r);
        xfer(1, 3'd6, 4'hF, 32'h0000_0003, r);
        xfer(1, 3'd7, 4'hF, 32'h0000_0010, r);
        xfer(0, 3'd1, 4'hF, 32'h0, r);
        check("out_rd", r, 32'h0000_00E3);
        check("gpio_out", 32'(out), 32'h0000_00E3);
        xfer(0, 3'd6, 4'hF, 32'h0, r);
        check("out_set_rd", r, 32'h0);

        xfer(1, 3'd0, 4'b0010, 32'hFFFF_FFFF, r);
        xfer(0, 3'd0, 4'hF, 32'h0, r);
        check("mode_bytemask", r, 32'h0000_FF0F);
        xfer(1, 3'd0, 4'hF, 32'hFFFF_FFFF, r);
        xfer(0, 3'd0, 4'hF, 32'h0, r);
        check("mode_upper0", r, 32'h00FF_FFFF);
        xfer(1, 3'd0, 4'hF, 32'h0000_000F, r);

        xfer(1, 3'd3, 4'hF, 32'h1, r);
        gin[0] = 1'b1;
        repeat (2) @(negedge clk);
        check("rise_irq_e2", 32'(irq), 32'h0);
        @(negedge clk);
        check("rise_irq_e3", 32'(irq), 32'h1);
        xfer(0, 3'd5, 4'hF, 32'h0, r);
        check("rise_pend", r, 32'h1);
        xfer(0, 3'd2, 4'hF, 32'h0, r);
        check("in_rd", r, 32'h1);
        xfer(1, 3'd5, 4'hF, 32'h1, r);
        xfer(0, 3'd5, 4'hF, 32'h0, r);
        check("w1c_pend", r, 32'h0);
        check("w1c_irq", 32'(irq), 32'h0);

        xfer(1, 3'd4, 4'hF, 32'h2, r);
        gin[1] = 1'b1;
        repeat (5) @(negedge clk);
        xfer(0, 3'd5, 4'hF, 32'h0, r);
        check("no_rise_pend", r, 32'h0);
        gin[1] = 1'b0;
        repeat (2) @(negedge clk);
        xfer(1, 3'd5, 4'hF, 32'h2, r);
        xfer(0, 3'd5, 4'hF, 32'h0, r);
        check("set_wins", r, 32'h2);
        xfer(1, 3'd5, 4'hF, 32'h2, r);
        xfer(0, 3'd5, 4'hF, 32'h0, r);
        check("pend_clr", r, 32'h0);
        @(negedge clk);

        req = 1; wrcs = 0; addr = 32'h0; mask = 4'hF; rdy = 0;
        @(negedge clk);
        req = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_rsp", 32'(rsp), 32'h1);
            check("stall_rdata", rdata, 32'h0000_000F);
            check("stall_gnt", 32'(gnt), 32'h0);
            @(negedge clk);
        end
        rdy = 1; req = 1; addr = 32'h0000_0004;
        #1 check("b2b_gnt", 32'(gnt), 32'h1);
        @(negedge clk);
        req = 0;
        check("b2b_rsp", 32'(rsp), 32'h1);
        check("b2b_rdata", rdata, 32'h0000_00E3);
        @(negedge clk);

        for (int c = 0; c < 1500; c++) begin
            req = 1'($urandom_range(0, 1));
            wrcs = 1'($urandom_range(0, 1));
            addr = $urandom;
            mask = 4'($urandom);
            wdata = $urandom;
            rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
                p = $urandom_range(0, W - 1);
                gin[p] = ~gin[p];
            end
            @(negedge clk);
        end
        req = 0; rdy = 1;
        repeat (3) @(negedge clk);

        gin = '1;
        rstn = 0;
        @(negedge clk);
        rstn = 1;
        xfer(1, 3'd3, 4'hF, 32'hFFFF_FFFF, r);
        repeat (8) @(negedge clk);
        xfer(0, 3'd5, 4'hF, 32'h0, r);
        check("arm_pend", r, 32'h0);
        check("arm_irq", 32'(irq), 32'h0);
        @(negedge clk);

        req = 1; wrcs = 0; addr = 32'h0000_000C; mask = 4'hF; rdy = 0;
        @(negedge clk);
        req = 0;
        check("pre_rst_rsp", 32'(rsp), 32'h1);
        #2 rstn = 0;
        #1;
        check("midrst_rsp", 32'(rsp), 32'h0);
        check("midrst_gnt", 32'(gnt), 32'h1);
        @(negedge clk);
        rstn = 1;
        @(negedge clk);
        check("postrst_rsp", 32'(rsp), 32'h0);
        check("postrst_gnt", 32'(gnt), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
